lv2_buf_mgr: RTL and testbench
==============================

// Module: lv2_buf_mgr
// PURPOSE
//  Level-2 buffer manager; sits directly upstream of the L2 reject counter.
//  - Turns raw L1 trigger accepts into the registered lv1a_req pulse.
//  - Tracks L2 buffer occupancy: +1 per accepted L1A, -1 per L2 drain.
//  - Drives lv2_buffer_full, so a request arriving while full is a reject downstream.
//  - Sequences run start/stop from in_live: IDLE/RUN/DRAIN state machine.
// PARAMETERS
//  DEPTH   8   number of L2 buffer slots; full when occupancy == DEPTH
//  CNT_W   4   occupancy width; must satisfy 2**CNT_W > DEPTH
// PORTS
//  clk              in   1      system clock; all logic on posedge
//  rst_n            in   1      reset, asynchronous, active-low
//  in_live          in   1      run live gate from run control
//  lv1a_trig        in   1      raw L1 accept, 1-cycle pulse per event
//  lv2_done         in   1      1-cycle pulse: one event drained from L2 buffer
//  lv1a_req         out  1      registered L1A request to L2 stage/reject counter
//  lv2_buffer_full  out  1      occupancy == DEPTH (decoded from occupancy reg)
//  occupancy        out  CNT_W  current number of filled L2 slots
//  lv1a_acc_cnt     out  32     L1As accepted into buffer since run start
//  run_state        out  2      00 IDLE, 01 RUN, 10 DRAIN
//  underflow_err    out  1      sticky: lv2_done seen with occupancy == 0
// BEHAVIOUR
//  Reset (rst_n=0, async):
//  - state=IDLE; lv1a_req=0, occupancy=0, lv1a_acc_cnt=0, underflow_err=0.
//  - lv2_buffer_full=0 follows from occupancy=0.
//  State machine (registered):
//  - IDLE -> RUN on in_live=1.
//    Same edge clears lv1a_acc_cnt and underflow_err; occupancy is kept.
//  - RUN -> DRAIN on in_live=0 with occupancy != 0.
//  - RUN -> IDLE on in_live=0 with occupancy == 0.
//  - DRAIN -> IDLE when occupancy == 0.
//  - DRAIN -> RUN on in_live=1 (no counter clear; same run resumes).
//  Request path:
//  - lv1a_req(N+1) = lv1a_trig(N) & in_live(N) & (state(N)==RUN).
//  - Always a 1-cycle pulse; back-to-back triggers give back-to-back pulses.
//  - Triggers seen in IDLE or DRAIN are dropped with no request.
//  - lv1a_req is raised regardless of full; downstream counts rejects.
//  Accept/occupancy:
//  - accept = lv1a_req & ~lv2_buffer_full.
//  - occupancy(N+1) = occupancy(N) + accept(N) - (lv2_done(N) & occupancy(N)!=0).
//  - Accept and drain in the same cycle: occupancy unchanged.
//  - Full and drain in the same cycle: request rejected, occupancy -> DEPTH-1.
//  - Occupancy never exceeds DEPTH and never goes below 0.
//  - lv2_done is honoured in every state, including IDLE.
//  - lv2_done with occupancy 0: ignored; underflow_err set until next run start.
//  - lv1a_acc_cnt += 1 on each accept; plain 32-bit wrap, FFFF_FFFF -> 0.
//  Latency:
//  - lv1a_trig to lv1a_req: 1 cycle.
//  - lv1a_trig to occupancy/full update: 2 cycles.
//  - lv2_done to occupancy update: 1 cycle.
//  Mid-operation reset:
//  - All state returns to reset values immediately; a pending request is lost.
// TESTING
//  1. Reset, in_live=1, one lv1a_trig -> lv1a_req high 1 cycle;
//     occupancy=1, lv1a_acc_cnt=1 two cycles after the trigger.
//  2. DEPTH=8, 10 back-to-back triggers, no drain -> occupancy saturates at 8;
//     lv2_buffer_full=1; 10 lv1a_req pulses, lv1a_acc_cnt=8.
//  3. Full buffer, lv1a_req and lv2_done in the same cycle -> occupancy=7,
//     acc count unchanged; next trigger accepted, occupancy=8.
//  4. occupancy=3, drop in_live -> DRAIN, triggers give no lv1a_req;
//     3 lv2_done pulses -> IDLE.
//     Raise in_live -> RUN with lv1a_acc_cnt=0.
//  5. IDLE, occupancy=0, lv2_done pulse -> underflow_err=1, occupancy stays 0;
//     next IDLE->RUN clears underflow_err.
//  6. Force lv1a_acc_cnt=FFFF_FFFF, one accept -> 0000_0000;
//     rst_n low mid-run -> all outputs 0 asynchronously, run_state=IDLE.

Source files
------------

// File: rtl/lv2_buf_mgr_if.sv
// Handshake bundle between run control / L1 trigger logic and the L2 buffer manager.
interface lv2_buf_mgr_if #(
   parameter int CNT_W = 4
);
   logic             in_live;
   logic             lv1a_trig;
   logic             lv2_done;
   logic             lv1a_req;
   logic             lv2_buffer_full;
   logic [CNT_W-1:0] occupancy;
   logic [31:0]      lv1a_acc_cnt;
   logic [1:0]       run_state;
   logic             underflow_err;

   modport master (
      output in_live, lv1a_trig, lv2_done,
      input  lv1a_req, lv2_buffer_full, occupancy, lv1a_acc_cnt, run_state, underflow_err
   );

   modport slave (
      input  in_live, lv1a_trig, lv2_done,
      output lv1a_req, lv2_buffer_full, occupancy, lv1a_acc_cnt, run_state, underflow_err
   );
endinterface

// File: rtl/lv2_buf_mgr.sv
// Level-2 buffer manager: registers L1A requests, tracks L2 buffer occupancy
// and sequences the run through IDLE/RUN/DRAIN from the in_live gate.
module lv2_buf_mgr #(
   parameter int DEPTH = 8,
   parameter int CNT_W = 4
) (
   input logic          clk,
   input logic          rst_n,
   lv2_buf_mgr_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      DRAIN = 2'b10
   } state_t;

   state_t           state;
   logic             req;
   logic [CNT_W-1:0] occ;
   logic [31:0]      acc_cnt;
   logic             underflow;

   logic occ_zero;
   logic full;
   logic accept;
   logic drain;

   // A request that meets a full buffer is dropped here; the reject counter sees it.
   assign occ_zero = (occ == '0);
   assign full     = (occ == CNT_W'(DEPTH));
   assign accept   = req & ~full;
   assign drain    = bus.lv2_done & ~occ_zero;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         req       <= 1'b0;
         occ       <= '0;
         acc_cnt   <= '0;
         underflow <= 1'b0;
      end else begin
         req <= bus.lv1a_trig & bus.in_live & (state == RUN);
         occ <= occ + CNT_W'(accept) - CNT_W'(drain);
         if (accept)
            acc_cnt <= acc_cnt + 32'd1;
         if (bus.lv2_done && occ_zero)
            underflow <= 1'b1;
         // Run start wins over a same-cycle underflow or accept: the new run starts clean.
         case (state)
            IDLE: begin
               if (bus.in_live) begin
                  state     <= RUN;
                  acc_cnt   <= '0;
                  underflow <= 1'b0;
               end
            end
            RUN: begin
               if (!bus.in_live)
                  state <= occ_zero ? IDLE : DRAIN;
            end
            DRAIN: begin
               if (occ_zero)
                  state <= IDLE;
               else if (bus.in_live)
                  state <= RUN;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.lv1a_req        = req;
   assign bus.lv2_buffer_full = full;
   assign bus.occupancy       = occ;
   assign bus.lv1a_acc_cnt    = acc_cnt;
   assign bus.run_state       = state;
   assign bus.underflow_err   = underflow;
endmodule

// File: tb/tb_lv2_buf_mgr.sv
// Bench for lv2_buf_mgr: directed scenarios plus a randomized run checked
// against an integer reference model of buffer occupancy and run sequencing.
module tb_lv2_buf_mgr;
   localparam int DEPTH = 8;
   localparam int CNT_W = 4;
   localparam logic [1:0] S_IDLE  = 2'b00;
   localparam logic [1:0] S_RUN   = 2'b01;
   localparam logic [1:0] S_DRAIN = 2'b10;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0;
   int errors = 0;

   // Reference model
   logic [1:0]  m_state;
   logic        m_req;
   int          m_occ;
   logic [31:0] m_acc;
   logic        m_uf;

   always #5 clk = ~clk;

   lv2_buf_mgr_if #(.CNT_W(CNT_W)) bus ();

   lv2_buf_mgr #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   task automatic model_reset();
      m_state = S_IDLE;
      m_req   = 1'b0;
      m_occ   = 0;
      m_acc   = 32'd0;
      m_uf    = 1'b0;
   endtask

   task automatic model_step(input logic live, input logic trig, input logic done);
      bit took;
      bit gave;
      took = m_req && (m_occ < DEPTH);
      gave = done && (m_occ > 0);
      if (done && m_occ == 0)
         m_uf = 1'b1;
      if (took)
         m_acc = m_acc + 32'd1;
      m_req = trig && live && (m_state == S_RUN);
      case (m_state)
         S_IDLE: if (live) begin
            m_state = S_RUN;
            m_acc   = 32'd0;
            m_uf    = 1'b0;
         end
         S_RUN: if (!live) m_state = (m_occ == 0) ? S_IDLE : S_DRAIN;
         default: begin
            if (m_occ == 0) m_state = S_IDLE;
            else if (live) m_state = S_RUN;
         end
      endcase
      m_occ = m_occ + int'(took) - int'(gave);
   endtask

   task automatic cycle(input logic live, input logic trig, input logic done);
      bus.in_live   = live;
      bus.lv1a_trig = trig;
      bus.lv2_done  = done;
      @(posedge clk);
      model_step(live, trig, done);
      #1;
   endtask

   task automatic do_reset();
      bus.in_live   = 1'b0;
      bus.lv1a_trig = 1'b0;
      bus.lv2_done  = 1'b0;
      rst_n = 1'b0;
      model_reset();
      #3;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (bus.lv1a_req !== 1'b0 || bus.occupancy !== '0 || bus.lv1a_acc_cnt !== 32'd0 ||
          bus.run_state !== S_IDLE || bus.underflow_err !== 1'b0 || bus.lv2_buffer_full !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_state: req=%b occ=%0d acc=%h state=%b uf=%b full=%b required all 0",
                  bus.lv1a_req, bus.occupancy, bus.lv1a_acc_cnt, bus.run_state, bus.underflow_err, bus.lv2_buffer_full);
      end
   endtask

   task automatic test_single_trigger();
      cycle(1, 0, 0);
      checks++;
      if (bus.run_state !== S_RUN) begin
         errors++; $display("[TB] FAIL start_run: state=%b required %b", bus.run_state, S_RUN);
      end
      cycle(1, 1, 0);
      checks++;
      if (bus.lv1a_req !== 1'b1 || bus.occupancy !== 4'd0) begin
         errors++; $display("[TB] FAIL single_req: req=%b occ=%0d required req=1 occ=0", bus.lv1a_req, bus.occupancy);
      end
      cycle(1, 0, 0);
      checks++;
      if (bus.lv1a_req !== 1'b0 || bus.occupancy !== 4'd1 || bus.lv1a_acc_cnt !== 32'd1) begin
         errors++;
         $display("[TB] FAIL single_accept: req=%b occ=%0d acc=%0d required req=0 occ=1 acc=1",
                  bus.lv1a_req, bus.occupancy, bus.lv1a_acc_cnt);
      end
   endtask

   task automatic test_back_to_back();
      int pulses = 0;
      do_reset();
      cycle(1, 0, 0);
      for (int i = 0; i < 10; i++) begin
         cycle(1, 1, 0);
         if (bus.lv1a_req === 1'b1) pulses++;
      end
      for (int i = 0; i < 2; i++) begin
         cycle(1, 0, 0);
         if (bus.lv1a_req === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 10) begin
         errors++; $display("[TB] FAIL b2b_pulses: got %0d required 10", pulses);
      end
      checks++;
      if (bus.occupancy !== 4'd8 || bus.lv2_buffer_full !== 1'b1) begin
         errors++; $display("[TB] FAIL b2b_saturate: occ=%0d full=%b required occ=8 full=1", bus.occupancy, bus.lv2_buffer_full);
      end
      checks++;
      if (bus.lv1a_acc_cnt !== 32'd8) begin
         errors++; $display("[TB] FAIL b2b_acc: acc=%0d required 8", bus.lv1a_acc_cnt);
      end
   endtask

   task automatic test_full_drain();
      cycle(1, 1, 0);
      cycle(1, 0, 1);
      checks++;
      if (bus.occupancy !== 4'd7 || bus.lv1a_acc_cnt !== 32'd8 || bus.lv2_buffer_full !== 1'b0) begin
         errors++;
         $display("[TB] FAIL full_drain: occ=%0d acc=%0d full=%b required occ=7 acc=8 full=0",
                  bus.occupancy, bus.lv1a_acc_cnt, bus.lv2_buffer_full);
      end
      cycle(1, 1, 0);
      cycle(1, 0, 0);
      checks++;
      if (bus.occupancy !== 4'd8 || bus.lv1a_acc_cnt !== 32'd9 || bus.lv2_buffer_full !== 1'b1) begin
         errors++;
         $display("[TB] FAIL refill: occ=%0d acc=%0d full=%b required occ=8 acc=9 full=1",
                  bus.occupancy, bus.lv1a_acc_cnt, bus.lv2_buffer_full);
      end
   endtask

   task automatic test_drain_state();
      do_reset();
      cycle(1, 0, 0);
      for (int i = 0; i < 3; i++) cycle(1, 1, 0);
      cycle(1, 0, 0);
      cycle(0, 0, 0);
      checks++;
      if (bus.run_state !== S_DRAIN || bus.occupancy !== 4'd3) begin
         errors++; $display("[TB] FAIL enter_drain: state=%b occ=%0d required state=10 occ=3", bus.run_state, bus.occupancy);
      end
      cycle(0, 1, 0);
      cycle(0, 0, 0);
      checks++;
      if (bus.lv1a_req !== 1'b0 || bus.occupancy !== 4'd3) begin
         errors++; $display("[TB] FAIL drain_drop: req=%b occ=%0d required req=0 occ=3", bus.lv1a_req, bus.occupancy);
      end
      for (int i = 0; i < 3; i++) cycle(0, 0, 1);
      cycle(0, 0, 0);
      checks++;
      if (bus.run_state !== S_IDLE || bus.occupancy !== 4'd0 || bus.lv1a_acc_cnt !== 32'd3) begin
         errors++;
         $display("[TB] FAIL drain_idle: state=%b occ=%0d acc=%0d required state=00 occ=0 acc=3",
                  bus.run_state, bus.occupancy, bus.lv1a_acc_cnt);
      end
      cycle(1, 0, 0);
      checks++;
      if (bus.run_state !== S_RUN || bus.lv1a_acc_cnt !== 32'd0) begin
         errors++; $display("[TB] FAIL restart_clear: state=%b acc=%0d required state=01 acc=0", bus.run_state, bus.lv1a_acc_cnt);
      end
   endtask

   task automatic test_underflow();
      cycle(0, 0, 0);
      cycle(0, 0, 1);
      checks++;
      if (bus.underflow_err !== 1'b1 || bus.occupancy !== 4'd0) begin
         errors++; $display("[TB] FAIL underflow_set: uf=%b occ=%0d required uf=1 occ=0", bus.underflow_err, bus.occupancy);
      end
      cycle(0, 0, 0);
      checks++;
      if (bus.underflow_err !== 1'b1) begin
         errors++; $display("[TB] FAIL underflow_sticky: uf=%b required 1", bus.underflow_err);
      end
      cycle(1, 0, 0);
      checks++;
      if (bus.underflow_err !== 1'b0 || bus.run_state !== S_RUN) begin
         errors++; $display("[TB] FAIL underflow_clear: uf=%b state=%b required uf=0 state=01", bus.underflow_err, bus.run_state);
      end
   endtask

   task automatic test_wrap_and_reset();
      force dut.acc_cnt = 32'hFFFF_FFFF;
      #1;
      release dut.acc_cnt;
      m_acc = 32'hFFFF_FFFF;
      checks++;
      if (bus.lv1a_acc_cnt !== 32'hFFFF_FFFF) begin
         errors++; $display("[TB] FAIL acc_preload: acc=%h required ffffffff", bus.lv1a_acc_cnt);
      end
      cycle(1, 1, 0);
      cycle(1, 0, 0);
      checks++;
      if (bus.lv1a_acc_cnt !== 32'h0000_0000 || bus.occupancy !== 4'd1) begin
         errors++; $display("[TB] FAIL acc_wrap: acc=%h occ=%0d required acc=00000000 occ=1", bus.lv1a_acc_cnt, bus.occupancy);
      end
      cycle(1, 1, 0);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      checks++;
      if (bus.lv1a_req !== 1'b0 || bus.occupancy !== '0 || bus.lv1a_acc_cnt !== 32'd0 ||
          bus.run_state !== S_IDLE || bus.underflow_err !== 1'b0 || bus.lv2_buffer_full !== 1'b0) begin
         errors++;
         $display("[TB] FAIL async_reset: req=%b occ=%0d acc=%h state=%b uf=%b full=%b required all 0",
                  bus.lv1a_req, bus.occupancy, bus.lv1a_acc_cnt, bus.run_state, bus.underflow_err, bus.lv2_buffer_full);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_random();
      logic live = 1'b0;
      do_reset();
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 24) == 0) live = ~live;
         cycle(live, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) < 3));
         checks++;
         if (bus.lv1a_req !== m_req || bus.occupancy !== CNT_W'(m_occ) ||
             bus.lv2_buffer_full !== (m_occ == DEPTH) || bus.lv1a_acc_cnt !== m_acc ||
             bus.run_state !== m_state || bus.underflow_err !== m_uf) begin
            errors++;
            $display("[TB] FAIL random_cycle%0d: req=%b occ=%0d full=%b acc=%0d state=%b uf=%b required req=%b occ=%0d full=%b acc=%0d state=%b uf=%b",
                     i, bus.lv1a_req, bus.occupancy, bus.lv2_buffer_full, bus.lv1a_acc_cnt, bus.run_state, bus.underflow_err,
                     m_req, m_occ, (m_occ == DEPTH), m_acc, m_state, m_uf);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_trigger();
      test_back_to_back();
      test_full_drain();
      test_drain_state();
      test_underflow();
      test_wrap_and_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
